ring_tx_scheduler: RTL and testbench

- Sole owner of the ring transmitter (serializer). It arbitrates between three sources: forwarded ring traffic, locally generated ACK/NACK responses, and the node's own transmissions (NEW packet or TOKEN release).
- It runs the token-holding protocol: at most one node packet per token hold, NACK/timeout retry up to a limit, then token release.
- Sits between the router receive/decode logic and the tx serializer. It drives the serializer's tx_data_select mux.

---
 rtl/ring_tx_scheduler.sv | 142 ++++++++++++++
 tb/tb_ring_tx_scheduler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ring_tx_scheduler.sv
// rtl/ring_tx_scheduler.sv - ring transmitter arbiter and token-holding FSM
// Arbitrates response, forward and own traffic onto the serializer; runs the send/retry/release protocol.
module ring_tx_scheduler #(
  parameter int MAX_RETRY   = 3,
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       Clk_R,
  input  logic       Rst_n,
  input  logic       tx_ready,
  input  logic       fwd_req,
  input  logic       rsp_req,
  input  logic       rsp_nack,
  input  logic       new_req,
  input  logic       token_rx,
  input  logic       ack_rx,
  input  logic       nack_rx,
  output logic       tx_start,
  output logic [2:0] tx_data_select,
  output logic       fwd_grant,
  output logic       rsp_grant,
  output logic       Core_Load_Ack,
  output logic       drop_err,
  output logic       token_dup_err,
  output logic       holding_token,
  output logic [1:0] retry_count
);

  typedef enum logic [2:0] {
    NO_TOKEN,
    HOLD,
    SEND_NEW,
    WAIT_RESP,
    RESEND,
    RELEASE
  } state_t;

  localparam logic [2:0] SEL_ACK  = 3'd0;
  localparam logic [2:0] SEL_NACK = 3'd1;
  localparam logic [2:0] SEL_FWD  = 3'd2;
  localparam logic [2:0] SEL_TOK  = 3'd3;
  localparam logic [2:0] SEL_NEW  = 3'd4;

  state_t           state;
  logic [CNT_W-1:0] timer;

  logic can_launch;
  logic own_req;
  logic rsp_go;
  logic fwd_go;
  logic own_go;
  logic timeout;
  logic retry_left;

  // Registered tx_start feeds back so back-to-back launches always get a dead cycle.
  assign can_launch = tx_ready && !tx_start;
  assign own_req    = (state == SEND_NEW) || (state == RESEND) || (state == RELEASE);
  assign rsp_go     = can_launch && rsp_req;
  assign fwd_go     = can_launch && !rsp_req && fwd_req;
  assign own_go     = can_launch && !rsp_req && !fwd_req && own_req;
  assign timeout    = (timer == CNT_W'(ACK_TIMEOUT));
  assign retry_left = (retry_count < 2'(MAX_RETRY));

  always_ff @(posedge Clk_R or negedge Rst_n) begin
    if (!Rst_n) begin
      state          <= NO_TOKEN;
      timer          <= '0;
      retry_count    <= '0;
      tx_start       <= 1'b0;
      tx_data_select <= SEL_ACK;
      fwd_grant      <= 1'b0;
      rsp_grant      <= 1'b0;
      Core_Load_Ack  <= 1'b0;
      drop_err       <= 1'b0;
      token_dup_err  <= 1'b0;
      holding_token  <= 1'b0;
    end else begin
      tx_start      <= rsp_go || fwd_go || own_go;
      rsp_grant     <= rsp_go;
      fwd_grant     <= fwd_go;
      Core_Load_Ack <= 1'b0;
      drop_err      <= 1'b0;
      token_dup_err <= token_rx && (state != NO_TOKEN);

      if (rsp_go)
        tx_data_select <= rsp_nack ? SEL_NACK : SEL_ACK;
      else if (fwd_go)
        tx_data_select <= SEL_FWD;
      else if (own_go)
        tx_data_select <= (state == RELEASE) ? SEL_TOK : SEL_NEW;

      case (state)
        NO_TOKEN: begin
          if (token_rx) begin
            state         <= HOLD;
            holding_token <= 1'b1;
          end
        end
        HOLD: state <= new_req ? SEND_NEW : RELEASE;
        SEND_NEW: begin
          if (own_go) begin
            state       <= WAIT_RESP;
            timer       <= '0;
            retry_count <= '0;
          end
        end
        WAIT_RESP: begin
          timer <= timer + 1'b1;
          // ACK dominates both a simultaneous NACK and the timeout.
          if (ack_rx) begin
            Core_Load_Ack <= 1'b1;
            state         <= RELEASE;
          end else if (nack_rx || timeout) begin
            if (retry_left) begin
              retry_count <= retry_count + 1'b1;
              state       <= RESEND;
            end else begin
              Core_Load_Ack <= 1'b1;
              drop_err      <= 1'b1;
              state         <= RELEASE;
            end
          end
        end
        RESEND: begin
          if (own_go) begin
            state <= WAIT_RESP;
            timer <= '0;
          end
        end
        RELEASE: begin
          if (own_go) begin
            state         <= NO_TOKEN;
            holding_token <= 1'b0;
            retry_count   <= '0;
          end
        end
        default: state <= NO_TOKEN;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_tx_scheduler.sv
// tb/tb_ring_tx_scheduler.sv - directed vector bench for ring_tx_scheduler
// Per-cycle vector table plus hand sequences for timeout, dup-token and async reset.
module tb_ring_tx_scheduler;
  localparam int ACK_TO = 255;

  logic       Clk_R = 1'b0;
  logic       Rst_n;
  logic       tx_ready, fwd_req, rsp_req, rsp_nack, new_req, token_rx, ack_rx, nack_rx;
  logic       tx_start, fwd_grant, rsp_grant, Core_Load_Ack, drop_err, token_dup_err, holding_token;
  logic [2:0] tx_data_select;
  logic [1:0] retry_count;

  int total = 0;
  int bad   = 0;

  ring_tx_scheduler #(.MAX_RETRY(3), .ACK_TIMEOUT(ACK_TO), .CNT_W(8)) dut (
    .Clk_R(Clk_R), .Rst_n(Rst_n), .tx_ready(tx_ready), .fwd_req(fwd_req),
    .rsp_req(rsp_req), .rsp_nack(rsp_nack), .new_req(new_req), .token_rx(token_rx),
    .ack_rx(ack_rx), .nack_rx(nack_rx), .tx_start(tx_start), .tx_data_select(tx_data_select),
    .fwd_grant(fwd_grant), .rsp_grant(rsp_grant), .Core_Load_Ack(Core_Load_Ack),
    .drop_err(drop_err), .token_dup_err(token_dup_err), .holding_token(holding_token),
    .retry_count(retry_count)
  );

  always #5 Clk_R = ~Clk_R;

  // Input bits: {tok, ack, nack, new, fwd, rsp, rsp_nack, rdy}
  typedef struct {
    logic [7:0]  in;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [11:0] e(bit ts, int sel, bit fg, bit rg, bit cla, bit drop,
                                    bit dup, bit hold, int rc);
    return {ts, 3'(sel), fg, rg, cla, drop, dup, hold, 2'(rc)};
  endfunction

  function automatic vec_t mk(logic [7:0] in, logic [11:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    return v;
  endfunction

  function automatic logic [11:0] outs();
    return {tx_start, tx_data_select, fwd_grant, rsp_grant, Core_Load_Ack, drop_err,
            token_dup_err, holding_token, retry_count};
  endfunction

  task automatic drive(logic [7:0] in);
    {token_rx, ack_rx, nack_rx, new_req, fwd_req, rsp_req, rsp_nack, tx_ready} = in;
  endtask

  task automatic step();
    @(posedge Clk_R);
    #1;
  endtask

  task automatic chk(string name, logic [11:0] got, logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_int(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    int n;
    // Single send, ACK, token release
    tbl.push_back(mk(8'b0000_0001, e(0,0,0,0,0,0,0,0,0)));
    tbl.push_back(mk(8'b1001_0001, e(0,0,0,0,0,0,0,1,0)));
    tbl.push_back(mk(8'b0001_0001, e(0,0,0,0,0,0,0,1,0)));
    tbl.push_back(mk(8'b0001_0001, e(1,4,0,0,0,0,0,1,0)));
    tbl.push_back(mk(8'b0000_0001, e(0,4,0,0,0,0,0,1,0)));
    tbl.push_back(mk(8'b0100_0001, e(0,4,0,0,1,0,0,1,0)));
    tbl.push_back(mk(8'b0000_0001, e(1,3,0,0,0,0,0,0,0)));
    tbl.push_back(mk(8'b0000_0001, e(0,3,0,0,0,0,0,0,0)));
    // Token with nothing to send
    tbl.push_back(mk(8'b1000_0001, e(0,3,0,0,0,0,0,1,0)));
    tbl.push_back(mk(8'b0000_0001, e(0,3,0,0,0,0,0,1,0)));
    tbl.push_back(mk(8'b0000_0001, e(1,3,0,0,0,0,0,0,0)));
    tbl.push_back(mk(8'b0000_0001, e(0,3,0,0,0,0,0,0,0)));
    // Priority NACK > FORWARD > NEW, then four NACKs to a drop
    tbl.push_back(mk(8'b1001_0001, e(0,3,0,0,0,0,0,1,0)));
    tbl.push_back(mk(8'b0001_1111, e(1,1,0,1,0,0,0,1,0)));
    tbl.push_back(mk(8'b0001_1001, e(0,1,0,0,0,0,0,1,0)));
    tbl.push_back(mk(8'b0001_1001, e(1,2,1,0,0,0,0,1,0)));
    tbl.push_back(mk(8'b0001_0001, e(0,2,0,0,0,0,0,1,0)));
    tbl.push_back(mk(8'b0001_0001, e(1,4,0,0,0,0,0,1,0)));
    tbl.push_back(mk(8'b0000_0001, e(0,4,0,0,0,0,0,1,0)));
    tbl.push_back(mk(8'b0010_0001, e(0,4,0,0,0,0,0,1,1)));
    tbl.push_back(mk(8'b0000_0001, e(1,4,0,0,0,0,0,1,1)));
    tbl.push_back(mk(8'b0010_0001, e(0,4,0,0,0,0,0,1,2)));
    tbl.push_back(mk(8'b0000_0001, e(1,4,0,0,0,0,0,1,2)));
    tbl.push_back(mk(8'b0010_0001, e(0,4,0,0,0,0,0,1,3)));
    tbl.push_back(mk(8'b0000_0001, e(1,4,0,0,0,0,0,1,3)));
    tbl.push_back(mk(8'b0010_0001, e(0,4,0,0,1,1,0,1,3)));
    tbl.push_back(mk(8'b0000_0001, e(1,3,0,0,0,0,0,0,0)));
    tbl.push_back(mk(8'b0000_0001, e(0,3,0,0,0,0,0,0,0)));
    // Stray ACK+NACK while idle; tx_ready low blocks the release
    tbl.push_back(mk(8'b0110_0001, e(0,3,0,0,0,0,0,0,0)));
    tbl.push_back(mk(8'b1000_0001, e(0,3,0,0,0,0,0,1,0)));
    tbl.push_back(mk(8'b0000_0001, e(0,3,0,0,0,0,0,1,0)));
    tbl.push_back(mk(8'b0000_0000, e(0,3,0,0,0,0,0,1,0)));
    tbl.push_back(mk(8'b0000_0001, e(1,3,0,0,0,0,0,0,0)));

    Rst_n = 1'b0;
    drive(8'b0000_0001);
    #1;
    chk("reset", outs(), e(0,0,0,0,0,0,0,0,0));
    step();
    step();
    Rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].in);
      step();
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Timeout: RESEND decision ACK_TO+1 cycles after the launch
    drive(8'b1001_0001);
    step();
    drive(8'b0001_0001);
    step();
    step();
    chk("to_launch", outs(), e(1,4,0,0,0,0,0,1,0));
    drive(8'b0000_0001);
    n = 0;
    do begin
      step();
      n++;
    end while (retry_count != 2'd1 && n < 400);
    chk_int("timeout_cycles", n, ACK_TO + 1);
    chk("timeout_state", outs(), e(0,4,0,0,0,0,0,1,1));
    step();
    chk("resend_launch", outs(), e(1,4,0,0,0,0,0,1,1));
    // ACK landing exactly in the timeout cycle wins
    repeat (ACK_TO) step();
    drive(8'b0100_0001);
    step();
    chk("ack_at_timeout", outs(), e(0,4,0,0,1,0,0,1,1));
    drive(8'b0000_0001);
    step();
    chk("release_after_ack", outs(), e(1,3,0,0,0,0,0,0,0));

    // Duplicate token in WAIT_RESP, then asynchronous reset
    drive(8'b1001_0001);
    step();
    drive(8'b0001_0001);
    step();
    step();
    drive(8'b0000_0001);
    step();
    drive(8'b1000_0001);
    step();
    chk("dup_token", outs(), e(0,4,0,0,0,0,1,1,0));
    drive(8'b0000_0001);
    step();
    chk("dup_cleared", outs(), e(0,4,0,0,0,0,0,1,0));
    #2;
    Rst_n = 1'b0;
    #1;
    chk("async_reset", outs(), e(0,0,0,0,0,0,0,0,0));
    step();
    Rst_n = 1'b1;
    drive(8'b1000_0001);
    step();
    chk("post_reset_token", outs(), e(0,0,0,0,0,0,0,1,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
